imem_loader: RTL

- Write-side counterpart of the instruction memory. The CPU only reads that memory, fetching by PC; this block fills it.
- Accepts a byte stream from a host over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes each word into instruction memory at consecutive word-aligned byte addresses.
- Holds the CPU stopped until the image is complete, then releases it by asserting cpu_run.

---
 rtl/imem_loader_pkg.sv | 30 +++
 rtl/imem_loader_assembler.sv | 47 ++++
 rtl/imem_loader.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
// Shared types and constants for the instruction-memory loader.
//   loader_state_t : loader FSM encoding
//   BYTES_PER_WORD : bytes assembled into one instruction word
//   HDR_BYTES      : bytes in the little-endian word-count header
//   cksum_step     : running XOR used by the optional image checksum
// -----------------------------------------------------------------------------
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR0  = 3'd1,
        HDR1  = 3'd2,
        DATA  = 3'd3,
        WRITE = 3'd4,
        CKSUM = 3'd5,
        DONE  = 3'd6,
        ERROR = 3'd7
    } loader_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int HDR_BYTES      = 2;

    // Fold one payload byte into the running image checksum.
    function automatic logic [7:0] cksum_step(input logic [7:0] acc, input logic [7:0] data_byte);
        return acc ^ data_byte;
    endfunction

endpackage

// File: rtl/imem_loader_assembler.sv
// -----------------------------------------------------------------------------
// word_assembler
// Packs a little-endian byte stream into 32-bit words.
//   clk, reset   : clock, asynchronous active-low reset
//   clr          : synchronous clear of lane counter and shift register
//   byte_en      : a byte is accepted this cycle
//   byte_in      : accepted byte
//   word         : assembled word; complete when word_full is high
//   word_full    : pulse in the cycle the last byte of a word is accepted
// -----------------------------------------------------------------------------
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_full
);

    localparam int LANE_W = $clog2(BYTES_PER_WORD);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES_PER_WORD - 1);

    logic [LANE_W-1:0] lane_r;
    logic [31:0]       shift_r;

    // Lane counter and byte shift register; bytes enter at the top so the first byte ends at [7:0].
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lane_r  <= {LANE_W{1'b0}};
            shift_r <= 32'd0;
        end else if (clr) begin
            lane_r  <= {LANE_W{1'b0}};
            shift_r <= 32'd0;
        end else if (byte_en) begin
            lane_r  <= lane_r + LANE_W'(1);
            shift_r <= {byte_in, shift_r[31:8]};
        end
    end

    // The final byte is merged combinationally so the word is usable on the accepting edge.
    assign word      = {byte_in, shift_r[31:8]};
    assign word_full = byte_en && (lane_r == LAST_LANE);

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Fills instruction memory from a host byte stream (16-bit LE word count, then
// N little-endian words) and releases the CPU once the image is written.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require a trailing byte
// equal to the XOR of all payload bytes before DONE.
//   clk, reset        : clock, asynchronous active-low reset
//   start             : arms a load from IDLE, DONE or ERROR
//   in_valid/in_data  : host byte stream, in_ready back-pressure
//   mem_we/addr/wdata : instruction memory write port (one cycle per word)
//   busy/done/error   : load status; cpu_run mirrors done
//   words_written     : words committed in the current load
// -----------------------------------------------------------------------------
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        cpu_run,
    output logic [15:0] words_written
);

    localparam int          HDR_BITS = HDR_BYTES * 8;
    localparam logic [HDR_BITS-1:0] DEPTH_W = HDR_BITS'(DEPTH);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam loader_state_t AFTER_LAST = CKSUM;
`else
    localparam loader_state_t AFTER_LAST = DONE;
`endif

    loader_state_t       state_r;
    loader_state_t       state_s;
    logic [7:0]          n_lo_r;
    logic [HDR_BITS-1:0] n_r;
    logic [HDR_BITS-1:0] n_s;
    logic [15:0]         words_r;
    logic [31:0]         mem_addr_r;
    logic [31:0]         mem_wdata_r;
    logic                byte_take_s;
    logic                arm_s;
    logic                last_word_s;
    logic                asm_en_s;
    logic [31:0]         word_s;
    logic                word_full_s;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]          cksum_r;
`endif

    assign byte_take_s = in_valid && in_ready;
    // start only arms from a resting state; while busy it is ignored.
    assign arm_s       = start && ((state_r == IDLE) || (state_r == DONE) || (state_r == ERROR));
    assign n_s         = {in_data, n_lo_r};
    assign last_word_s = ((words_r + 16'd1) == n_r);
    assign asm_en_s    = byte_take_s && (state_r == DATA);

    word_assembler u_asm (
        .clk       (clk),
        .reset     (reset),
        .clr       (arm_s),
        .byte_en   (asm_en_s),
        .byte_in   (in_data),
        .word      (word_s),
        .word_full (word_full_s)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_s = HDR0;
                else       state_s = IDLE;
            end
            HDR0: begin
                if (byte_take_s) state_s = HDR1;
                else             state_s = HDR0;
            end
            HDR1: begin
                if (byte_take_s) begin
                    if (n_s == 16'd0)        state_s = AFTER_LAST;
                    else if (n_s > DEPTH_W)  state_s = ERROR;
                    else                     state_s = DATA;
                end else begin
                    state_s = HDR1;
                end
            end
            DATA: begin
                if (word_full_s) state_s = WRITE;
                else             state_s = DATA;
            end
            WRITE: begin
                if (last_word_s) state_s = AFTER_LAST;
                else             state_s = DATA;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CKSUM: begin
                if (byte_take_s) begin
                    if (in_data == cksum_r) state_s = DONE;
                    else                    state_s = ERROR;
                end else begin
                    state_s = CKSUM;
                end
            end
`endif
            DONE, ERROR: begin
                if (start) state_s = HDR0;
                else       state_s = state_r;
            end
            default: state_s = IDLE;
        endcase
    end

    // Output decode from the state register.
    always_comb begin
        in_ready = 1'b0;
        mem_we   = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        error    = 1'b0;
        cpu_run  = 1'b0;
        case (state_r)
            HDR0, HDR1, DATA: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            WRITE: begin
                mem_we = 1'b1;
                busy   = 1'b1;
            end
            CKSUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            DONE: begin
                done    = 1'b1;
                cpu_run = 1'b1;
            end
            ERROR: begin
                error = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // Header latch, word counter, checksum and write-port registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            n_lo_r      <= 8'd0;
            n_r         <= 16'd0;
            words_r     <= 16'd0;
            mem_addr_r  <= 32'd0;
            mem_wdata_r <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            cksum_r     <= 8'd0;
`endif
        end else if (arm_s) begin
            n_lo_r  <= 8'd0;
            n_r     <= 16'd0;
            words_r <= 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            cksum_r <= 8'd0;
`endif
        end else begin
            if ((state_r == HDR0) && byte_take_s) n_lo_r <= in_data;
            if ((state_r == HDR1) && byte_take_s) n_r    <= n_s;
            // Address/data are captured on entry to WRITE and then held until the next word.
            if (word_full_s) begin
                mem_addr_r  <= BASE_ADDR + {14'd0, words_r, 2'b00};
                mem_wdata_r <= word_s;
            end
            if ((state_r == WRITE) && (words_r != n_r)) words_r <= words_r + 16'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (asm_en_s) cksum_r <= cksum_step(cksum_r, in_data);
`endif
        end
    end

    assign mem_addr      = mem_addr_r;
    assign mem_wdata     = mem_wdata_r;
    assign words_written = words_r;

endmodule
